instr_mem_loader: RTL and testbench

Writer side of the instruction memory. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and emits one byte-write per payload byte to the instruction memory's write port, starting at byte offset 0. It holds the CPU in reset while a load is in progress and reports done or error. It sits between the host/debug byte source and the instruction memory.

---
 rtl/instr_mem_loader_pkg.sv | 23 ++
 rtl/instr_mem_loader_if.sv | 23 ++
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader and the memory it writes.
package loader_pkg;

  localparam int MEM_BYTES    = 2048;
  localparam int OFFSET_WIDTH = $clog2(MEM_BYTES);
  localparam int DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  // A frame must carry at least one byte and must fit in the instruction array.
  function automatic logic len_ok(input logic [15:0] n, input int max_bytes);
    return (n != 16'd0) && (n <= 16'(max_bytes));
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface instr_mem_loader_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 11
);
  logic                    in_valid;
  logic [7:0]              in_data;
  logic                    in_ready;
  logic                    we;
  logic [OFFSET_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]   wdata;

  // master: the loader itself; slave: byte source plus memory side.
  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Parses LEN_LO, LEN_HI, payload, CHK frames and writes the payload into instruction
// memory from offset 0, holding the CPU in reset until a good frame has landed.
module instr_mem_loader #(
  parameter int DATA_WIDTH   = loader_pkg::DATA_WIDTH,
  parameter int MEM_BYTES    = loader_pkg::MEM_BYTES,
  parameter int OFFSET_WIDTH = loader_pkg::OFFSET_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  instr_mem_loader_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      cpu_rst
);
  import loader_pkg::*;

  loader_state_t           r_state;
  loader_state_t           w_next;
  logic [7:0]              r_len_lo;
  logic [15:0]             r_rem;
  logic [OFFSET_WIDTH-1:0] r_off;
  logic [7:0]              r_acc;
  logic                    r_we;
  logic [OFFSET_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_start;
  logic [15:0]             w_len;
  logic [7:0]              w_chk;

  assign w_xfer  = bus.in_valid && w_ready;
  assign w_len   = {bus.in_data, r_len_lo};
  assign w_chk   = r_acc + bus.in_data;
  assign w_start = start && (r_state == IDLE || r_state == DONE || r_state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    cpu_rst = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = LEN_LO;
      end
      LEN_LO: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        cpu_rst = 1'b1;
        if (w_xfer) w_next = LEN_HI;
      end
      LEN_HI: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        cpu_rst = 1'b1;
        if (w_xfer) w_next = len_ok(w_len, MEM_BYTES) ? DATA : ERR;
      end
      DATA: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        cpu_rst = 1'b1;
        if (w_xfer && r_rem == 16'd1) w_next = CHECK;
      end
      CHECK: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        cpu_rst = 1'b1;
        if (w_xfer) w_next = (w_chk == 8'd0) ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = LEN_LO;
      end
      ERR: begin
        error   = 1'b1;
        cpu_rst = 1'b1;
        if (start) w_next = LEN_LO;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter, accumulator and the one-cycle-delayed write register; the offset may
  // roll over after the final byte of a full-size frame, which is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_lo <= '0;
      r_rem    <= '0;
      r_off    <= '0;
      r_acc    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_len_lo <= '0;
        r_rem    <= '0;
        r_off    <= '0;
        r_acc    <= '0;
      end
      if (w_xfer) begin
        if (r_state == LEN_LO) r_len_lo <= bus.in_data;
        if (r_state == LEN_HI) r_rem <= w_len;
        if (r_state == DATA) begin
          r_we    <= 1'b1;
          r_waddr <= r_off;
          r_wdata <= bus.in_data;
          r_off   <= r_off + 1'b1;
          r_acc   <= w_chk;
          r_rem   <= r_rem - 16'd1;
        end
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard checked on the falling edge.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, cpu_rst;

  instr_mem_loader_if #(.DATA_WIDTH(8), .OFFSET_WIDTH(11)) bus ();

  instr_mem_loader #(.DATA_WIDTH(8), .MEM_BYTES(2048), .OFFSET_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] a; logic [7:0] d; int cyc; } wr_t;
  wr_t         sb[$];
  logic [7:0]  pay[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_we = 0;
  logic [10:0] exp_off = '0;
  logic [10:0] last_waddr = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.we === 1'b1) begin
        wr_t e;
        n_we++;
        last_waddr = bus.waddr;
        if (sb.size() == 0) check("we_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("waddr", 32'(bus.waddr), 32'(e.a));
          check("wdata", 32'(bus.wdata), 32'(e.d));
          check("we_latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        void'(sb.pop_front());
        check("we_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit payload, input bit stall);
    bit got = 1'b0;
    if (stall) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) check("xfer_timeout", 32'd0, 32'd1);
    else if (payload) begin
      sb.push_back('{exp_off, d, cyc + 1});
      exp_off++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk, input bit stall);
    int n = pay.size();
    send_byte(n[7:0], 1'b0, stall);
    send_byte(n[15:8], 1'b0, stall);
    for (int i = 0; i < n; i++) send_byte(pay[i], 1'b1, stall);
    send_byte(chk, 1'b0, stall);
  endtask

  task automatic wait_end();
    bit fin = 1'b0;
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clk);
      if (done || error) fin = 1'b1;
    end
    if (!fin) check("end_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] neg_sum();
    logic [7:0] s = 8'd0;
    foreach (pay[i]) s += pay[i];
    return 8'(-s);
  endfunction

  task automatic new_test();
    n_we = 0;
    exp_off = '0;
    sb.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check("reset_outputs", 32'({bus.in_ready, bus.we, busy, done, error, cpu_rst}), 32'd0);
    check("reset_waddr_wdata", 32'({bus.waddr, bus.wdata}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // good frame, no stalls
    new_test();
    pay = '{8'h13, 8'h05, 8'hA0, 8'h00};
    do_start();
    check("busy_after_start", 32'({busy, cpu_rst, bus.in_ready}), 32'b111);
    send_frame(8'h48, 1'b0);
    wait_end();
    check("good_status", 32'({done, error, cpu_rst, busy}), 32'b1000);
    check("good_nwe", 32'(n_we), 32'd4);

    // bad checksum
    new_test();
    do_start();
    send_frame(8'h49, 1'b0);
    wait_end();
    check("badchk_status", 32'({done, error, cpu_rst, bus.in_ready}), 32'b0110);
    check("badchk_nwe", 32'(n_we), 32'd4);

    // zero length
    new_test();
    do_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    wait_end();
    check("len0_status", 32'({done, error, busy}), 32'b010);
    check("len0_nwe", 32'(n_we), 32'd0);

    // length 2049
    new_test();
    do_start();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    wait_end();
    check("len2049_status", 32'({done, error}), 32'b01);
    check("len2049_nwe", 32'(n_we), 32'd0);

    // full-size 2048-byte frame
    new_test();
    pay.delete();
    for (int i = 0; i < 2048; i++) pay.push_back(8'(i * 7 + 3));
    do_start();
    send_frame(neg_sum(), 1'b0);
    wait_end();
    check("len2048_status", 32'({done, error, cpu_rst}), 32'b100);
    check("len2048_nwe", 32'(n_we), 32'd2048);
    check("len2048_last_waddr", 32'(last_waddr), 32'h7FF);

    // stalls with garbage data while in_valid is low
    new_test();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_start();
    send_frame(neg_sum(), 1'b1);
    wait_end();
    check("stall_status", 32'({done, error}), 32'b10);
    check("stall_nwe", 32'(n_we), 32'd5);

    // reset mid-load after the second payload byte
    new_test();
    do_start();
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({bus.in_ready, bus.we, busy, done, error, cpu_rst}), 32'd0);
    check("midrst_waddr_wdata", 32'({bus.waddr, bus.wdata}), 32'd0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    new_test();
    pay = '{8'h13, 8'h05, 8'hA0, 8'h00};
    do_start();
    send_frame(8'h48, 1'b0);
    wait_end();
    check("after_rst_status", 32'({done, error, cpu_rst}), 32'b100);
    check("after_rst_nwe", 32'(n_we), 32'd4);

    // start pulsed during DATA is ignored
    new_test();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_start();
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(pay[0], 1'b1, 1'b0);
    send_byte(pay[1], 1'b1, 1'b0);
    do_start();
    check("start_ignored_busy", 32'({busy, bus.in_ready}), 32'b11);
    send_byte(pay[2], 1'b1, 1'b0);
    send_byte(pay[3], 1'b1, 1'b0);
    send_byte(neg_sum(), 1'b0, 1'b0);
    wait_end();
    check("start_busy_status", 32'({done, error}), 32'b10);
    check("start_busy_nwe", 32'(n_we), 32'd4);

    // start from DONE clears done and re-opens the stream
    do_start();
    @(negedge clk);
    check("restart_from_done", 32'({done, error, bus.in_ready, busy, cpu_rst}), 32'b00111);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
